// File: rtl/csr_reg.sv
// ============================================================================
// csr_reg : RV32I machine-mode CSR file with bypassed decode read port,
//           prioritised execute/clint writes and optional 64-bit cycle counter
//           (cycle counter built only when CSR_CYCLE_EN is defined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module csr_reg #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  input  logic        ex_we_i,
  input  logic [31:0] ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        clint_we_i,
  input  logic [31:0] clint_waddr_i,
  input  logic [31:0] clint_wdata_i,
  input  logic [31:0] clint_raddr_i,
  output logic [31:0] clint_rdata_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic        global_int_en_o
);

  localparam logic [11:0] c_addr_mstatus  = 12'h300;
  localparam logic [11:0] c_addr_mie      = 12'h304;
  localparam logic [11:0] c_addr_mtvec    = 12'h305;
  localparam logic [11:0] c_addr_mscratch = 12'h340;
  localparam logic [11:0] c_addr_mepc     = 12'h341;
  localparam logic [11:0] c_addr_mcause   = 12'h342;
  localparam logic [11:0] c_addr_mcycle   = 12'hB00;
  localparam logic [11:0] c_addr_mcycleh  = 12'hB80;
  localparam logic [11:0] c_addr_cycle    = 12'hC00;
  localparam logic [11:0] c_addr_cycleh   = 12'hC80;

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic [11:0] w_ex_addr;
  logic [11:0] w_cl_addr;
  logic [11:0] w_rd_canon;
  logic [11:0] w_crd_canon;
  logic        w_unused_addr_bits;

  assign w_ex_addr = ex_waddr_i[11:0];
  assign w_cl_addr = clint_waddr_i[11:0];
  assign w_unused_addr_bits = ^{csr_raddr_i[31:12], ex_waddr_i[31:12],
                                clint_waddr_i[31:12], clint_raddr_i[31:12]};

  // Read-only counter aliases resolve onto their machine-mode counterparts.
  function automatic logic [11:0] csr_canon(input logic [11:0] addr);
    if (addr == c_addr_cycle)       return c_addr_mcycle;
    else if (addr == c_addr_cycleh) return c_addr_mcycleh;
    else                            return addr;
  endfunction

  function automatic logic csr_mapped(input logic [11:0] addr);
    case (addr)
      c_addr_mstatus, c_addr_mie, c_addr_mtvec,
      c_addr_mscratch, c_addr_mepc, c_addr_mcause: return 1'b1;
`ifdef CSR_CYCLE_EN
      c_addr_mcycle, c_addr_mcycleh:               return 1'b1;
`endif
      default:                                     return 1'b0;
    endcase
  endfunction

`ifdef CSR_CYCLE_EN
  logic [31:0] mcycle_q, mcycle_d;
  logic [31:0] mcycleh_q, mcycleh_d;
  logic [63:0] w_cycle_inc;

  assign w_cycle_inc = {mcycleh_q, mcycle_q} + 64'd1;

  // A written half takes the write data; the other half keeps the increment.
  always_comb begin
    mcycle_d  = w_cycle_inc[31:0];
    mcycleh_d = w_cycle_inc[63:32];
    if (ex_we_i && (w_ex_addr == c_addr_mcycle))     mcycle_d  = ex_wdata_i;
    if (ex_we_i && (w_ex_addr == c_addr_mcycleh))    mcycleh_d = ex_wdata_i;
    if (clint_we_i && (w_cl_addr == c_addr_mcycle))  mcycle_d  = clint_wdata_i;
    if (clint_we_i && (w_cl_addr == c_addr_mcycleh)) mcycleh_d = clint_wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q  <= 32'h0;
      mcycleh_q <= 32'h0;
    end else begin
      mcycle_q  <= mcycle_d;
      mcycleh_q <= mcycleh_d;
    end
  end
`endif

  function automatic logic [31:0] csr_stored(input logic [11:0] addr);
    case (addr)
      c_addr_mstatus:  return mstatus_q;
      c_addr_mie:      return mie_q;
      c_addr_mtvec:    return mtvec_q;
      c_addr_mscratch: return mscratch_q;
      c_addr_mepc:     return mepc_q;
      c_addr_mcause:   return mcause_q;
`ifdef CSR_CYCLE_EN
      c_addr_mcycle:   return mcycle_q;
      c_addr_mcycleh:  return mcycleh_q;
`endif
      default:         return 32'h0;
    endcase
  endfunction

  // The clint write is applied last so it overrides an ex write to the same CSR.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (ex_we_i) begin
      case (w_ex_addr)
        c_addr_mstatus:  mstatus_d  = ex_wdata_i;
        c_addr_mie:      mie_d      = ex_wdata_i;
        c_addr_mtvec:    mtvec_d    = ex_wdata_i;
        c_addr_mscratch: mscratch_d = ex_wdata_i;
        c_addr_mepc:     mepc_d     = ex_wdata_i;
        c_addr_mcause:   mcause_d   = ex_wdata_i;
        default: ;
      endcase
    end
    if (clint_we_i) begin
      case (w_cl_addr)
        c_addr_mstatus:  mstatus_d  = clint_wdata_i;
        c_addr_mie:      mie_d      = clint_wdata_i;
        c_addr_mtvec:    mtvec_d    = clint_wdata_i;
        c_addr_mscratch: mscratch_d = clint_wdata_i;
        c_addr_mepc:     mepc_d     = clint_wdata_i;
        c_addr_mcause:   mcause_d   = clint_wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= 32'h0;
      mie_q      <= 32'h0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign w_rd_canon  = csr_canon(csr_raddr_i[11:0]);
  assign w_crd_canon = csr_canon(clint_raddr_i[11:0]);

  // Bypass only forwards writes that will actually be stored.
  always_comb begin
    csr_rdata_o = 32'h0;
    if (csr_mapped(w_rd_canon)) begin
      if (clint_we_i && (w_cl_addr == w_rd_canon))   csr_rdata_o = clint_wdata_i;
      else if (ex_we_i && (w_ex_addr == w_rd_canon)) csr_rdata_o = ex_wdata_i;
      else                                           csr_rdata_o = csr_stored(w_rd_canon);
    end
  end

  assign clint_rdata_o   = csr_stored(w_crd_canon);
  assign mtvec_o         = mtvec_q;
  assign mepc_o          = mepc_q;
  assign mstatus_o       = mstatus_q;
  assign global_int_en_o = mstatus_q[3];

endmodule

`default_nettype wire

// File: tb/tb_csr_reg.sv
// ============================================================================
// tb_csr_reg : randomized self-checking bench for csr_reg against a
//              behavioural CSR model (counter modelled when CSR_CYCLE_EN set).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_csr_reg;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
`ifdef CSR_CYCLE_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] csr_raddr_i, csr_rdata_o;
  logic        ex_we_i;
  logic [31:0] ex_waddr_i, ex_wdata_i;
  logic        clint_we_i;
  logic [31:0] clint_waddr_i, clint_wdata_i, clint_raddr_i, clint_rdata_o;
  logic [31:0] mtvec_o, mepc_o, mstatus_o;
  logic        global_int_en_o;

  int checks = 0;
  int errors = 0;

  csr_reg #(.MTVEC_RESET(MTVEC_RST)) dut (
    .clk            (clk),
    .rst            (rst),
    .csr_raddr_i    (csr_raddr_i),
    .csr_rdata_o    (csr_rdata_o),
    .ex_we_i        (ex_we_i),
    .ex_waddr_i     (ex_waddr_i),
    .ex_wdata_i     (ex_wdata_i),
    .clint_we_i     (clint_we_i),
    .clint_waddr_i  (clint_waddr_i),
    .clint_wdata_i  (clint_wdata_i),
    .clint_raddr_i  (clint_raddr_i),
    .clint_rdata_o  (clint_rdata_o),
    .mtvec_o        (mtvec_o),
    .mepc_o         (mepc_o),
    .mstatus_o      (mstatus_o),
    .global_int_en_o(global_int_en_o)
  );

  always #5 clk = ~clk;

  // Reference model: one word per 12-bit address plus a 64-bit counter.
  logic [31:0] m_csr [0:4095];
  logic [63:0] m_cyc;

  function automatic bit m_rw(input logic [11:0] a);
    if (a == 12'h300 || a == 12'h304 || a == 12'h305 ||
        a == 12'h340 || a == 12'h341 || a == 12'h342) return 1'b1;
    if (a == 12'hB00 || a == 12'hB80) return CYC_EN;
    return 1'b0;
  endfunction

  function automatic logic [11:0] m_canon(input logic [11:0] a);
    if (a == 12'hC00) return 12'hB00;
    if (a == 12'hC80) return 12'hB80;
    return a;
  endfunction

  function automatic logic [31:0] m_stored(input logic [11:0] a);
    if (!m_rw(a))      return 32'h0;
    if (a == 12'hB00)  return m_cyc[31:0];
    if (a == 12'hB80)  return m_cyc[63:32];
    return m_csr[a];
  endfunction

  function automatic logic [31:0] m_read_dec(input logic [31:0] addr);
    logic [11:0] c;
    c = m_canon(addr[11:0]);
    if (!m_rw(c)) return 32'h0;
    if (clint_we_i && clint_waddr_i[11:0] == c) return clint_wdata_i;
    if (ex_we_i && ex_waddr_i[11:0] == c)       return ex_wdata_i;
    return m_stored(c);
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] d, inout logic [63:0] nxt);
    if (!m_rw(a)) return;
    if (a == 12'hB00)      nxt[31:0]  = d;
    else if (a == 12'hB80) nxt[63:32] = d;
    else                   m_csr[a]   = d;
  endtask

  task automatic m_update();
    logic [63:0] nxt;
    if (rst) begin
      foreach (m_csr[i]) m_csr[i] = 32'h0;
      m_csr[12'h305] = MTVEC_RST;
      m_cyc = 64'h0;
    end else begin
      nxt = m_cyc + 64'd1;
      if (ex_we_i && !(clint_we_i && clint_waddr_i[11:0] == ex_waddr_i[11:0]))
        m_write(ex_waddr_i[11:0], ex_wdata_i, nxt);
      if (clint_we_i)
        m_write(clint_waddr_i[11:0], clint_wdata_i, nxt);
      if (CYC_EN) m_cyc = nxt;
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Inputs are set at posedge+1; outputs compared at the following negedge.
  task automatic tick(input bit chk);
    @(negedge clk);
    if (chk) begin
      check32("csr_rdata", csr_rdata_o, m_read_dec(csr_raddr_i));
      check32("clint_rdata", clint_rdata_o, m_stored(m_canon(clint_raddr_i[11:0])));
      check32("mtvec_o", mtvec_o, m_csr[12'h305]);
      check32("mepc_o", mepc_o, m_csr[12'h341]);
      check32("mstatus_o", mstatus_o, m_csr[12'h300]);
      check32("gie_o", {31'h0, global_int_en_o}, {31'h0, m_csr[12'h300][3]});
    end
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; ex_we_i = 1'b0; clint_we_i = 1'b0;
    ex_waddr_i = 32'h0; ex_wdata_i = 32'h0;
    clint_waddr_i = 32'h0; clint_wdata_i = 32'h0;
  endtask

  task automatic ex_wr(input logic [31:0] a, input logic [31:0] d);
    ex_we_i = 1'b1; ex_waddr_i = a; ex_wdata_i = d;
  endtask

  task automatic cl_wr(input logic [31:0] a, input logic [31:0] d);
    clint_we_i = 1'b1; clint_waddr_i = a; clint_wdata_i = d;
  endtask

  logic [11:0] addr_pool [0:11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'hB00, 12'hB80, 12'hC00, 12'hC80, 12'h7FF, 12'h301};

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {20'h0, addr_pool[$urandom_range(0, 11)]};
    if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
    if ($urandom_range(0, 15) == 0) a[11:0] = 12'($urandom);
    return a;
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'hFFFF_FFFD;
      2:       return 32'h0000_0008;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    csr_raddr_i = 32'h341; clint_raddr_i = 32'h341;
    @(posedge clk); #1;
    m_update();
    tick(1'b0);
    idle();
    check32("mtvec_rst", mtvec_o, 32'h0000_0100);
    check32("mepc_rst", mepc_o, 32'h0);

    csr_raddr_i = 32'hC00;
    repeat (5) tick(1'b1);

    idle(); ex_wr(32'h340, 32'hDEAD_BEEF);
    csr_raddr_i = 32'h340; clint_raddr_i = 32'h340;
    tick(1'b1);
    idle(); tick(1'b1);

    idle(); ex_wr(32'h341, 32'h1111_1111); cl_wr(32'h341, 32'h2222_2222);
    csr_raddr_i = 32'h341;
    tick(1'b1);
    check32("mepc_prio", mepc_o, 32'h2222_2222);

    idle(); ex_wr(32'hB00, 32'hFFFF_FFFF); csr_raddr_i = 32'hC00; tick(1'b1);
    idle(); tick(1'b1);
    csr_raddr_i = 32'hC80; clint_raddr_i = 32'hC00; tick(1'b1);

    idle(); ex_wr(32'h300, 32'h8); tick(1'b1);
    idle(); ex_wr(32'hC00, 32'h5); cl_wr(32'h7FF, 32'h1); csr_raddr_i = 32'h7FF; tick(1'b1);
    check32("gie_set", {31'h0, global_int_en_o}, 32'h1);
    idle(); csr_raddr_i = 32'hC00; tick(1'b1);

    idle(); ex_wr(32'hB00, 32'hFFFF_FFFF); cl_wr(32'hB80, 32'hFFFF_FFFF); tick(1'b1);
    idle(); csr_raddr_i = 32'hC80; clint_raddr_i = 32'hB00; tick(1'b1);

    idle(); rst = 1'b1; ex_wr(32'h305, 32'hABCD_0000); tick(1'b1);
    check32("mtvec_rst2", mtvec_o, 32'h0000_0100);
    idle(); csr_raddr_i = 32'hC00; tick(1'b1);
    tick(1'b1);

    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1) ex_wr(rand_addr(), rand_data());
      if ($urandom_range(0, 2) == 0)
        cl_wr(($urandom_range(0, 2) == 0) ? ex_waddr_i : rand_addr(), rand_data());
      csr_raddr_i   = ($urandom_range(0, 2) == 0 && ex_we_i) ? ex_waddr_i : rand_addr();
      clint_raddr_i = rand_addr();
      tick(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/csr_reg.md
# csr_reg

Machine-mode CSR file for the RV32I core. It sits beside the integer register file and answers the decode stage's CSR read port (`csr_raddr_o`/`csr_rdata_i` on the decode side). It accepts CSR writes from the execute stage and from the interrupt controller (clint). It also runs the 64-bit cycle counter and exports the trap-related CSRs to the clint.

## Interface
Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- csr_raddr_i  in  32  decode read address; only [11:0] decoded.
- csr_rdata_o  out  32  decode read data, combinational.
- ex_we_i  in  1  execute-stage write enable.
- ex_waddr_i  in  32  execute-stage write address; [11:0] decoded.
- ex_wdata_i  in  32  execute-stage write data.
- clint_we_i  in  1  clint write enable.
- clint_waddr_i  in  32  clint write address.
- clint_wdata_i  in  32  clint write data.
- clint_raddr_i  in  32  clint read address.
- clint_rdata_o  out  32  clint read data, combinational.
- mtvec_o  out  32  current mtvec.
- mepc_o  out  32  current mepc.
- mstatus_o  out  32  current mstatus.
- global_int_en_o  out  1  mstatus[3] (MIE).

## Operation
- Implemented CSRs:
  - Read/write: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80.
  - Read-only aliases: cycle 0xC00 and cycleh 0xC80 return mcycle and mcycleh.
- All read/write CSRs store the full 32 bits. There is no field masking.
- Unmapped addresses:
  - Reads return 32'h0.
  - Writes are ignored.
- Writes to 0xC00 and 0xC80 are ignored.
- Cycle counter:
  - 64-bit register, {mcycleh, mcycle}.
  - Increments by 1 every clock with rst low.
  - Carries from the low word into the high word.
  - Wraps from all-ones to 0.
- Counter writes:
  - A write to mcycle replaces the low word that edge. The high word still receives the carry the increment would have produced.
  - A write to mcycleh replaces the high word that edge. The low word still increments.
  - No increment is applied to the written half on that edge.
- Write priority: if clint_we_i and ex_we_i target the same CSR in the same cycle, the clint write wins and the ex write to that CSR is dropped. Writes to different CSRs both commit.
- Read bypass:
  - csr_rdata_o returns ex_wdata_i when ex_we_i is high and ex_waddr_i[11:0] equals csr_raddr_i[11:0]. If clint writes the same address that cycle, it returns clint_wdata_i instead. Otherwise it returns the stored value.
  - Bypass also applies through the aliases: a write to 0xB00 is visible on a read of 0xC00 in the same cycle.
  - clint_rdata_o has no bypass and returns stored values only.
- Exports: mtvec_o, mepc_o, mstatus_o and global_int_en_o come from registered values with no bypass.

## Timing
- Reset (rst high at an edge):
  - mtvec = MTVEC_RESET.
  - All other CSRs and the counter = 0.
  - global_int_en_o = 0.
  - Counter holds 0 while rst is high.
- First rising edge with rst low: counter becomes 1.
- Reset has priority over any simultaneous write. A write presented in the reset cycle is lost.
- Write latency:
  - Stored value and exported outputs update at the edge following the write cycle.
  - Decode read latency is 0 cycles via the bypass.
- Read latency: both read ports are purely combinational from address to data.
- Boundary cases:
  - Counter 64'h0000_0000_FFFF_FFFF rolls to 64'h0000_0001_0000_0000.
  - Counter 64'hFFFF_FFFF_FFFF_FFFF rolls to 0.

## Configuration
- CSR_CYCLE_EN
  - Defined: cycle counter and addresses 0xB00, 0xB80, 0xC00, 0xC80 behave as above.
  - Undefined: no counter flops are built. Those four addresses read 0 and writes to them are ignored, like unmapped addresses.

## Test plan
- Reset with MTVEC_RESET=32'h0000_0100 -> mtvec_o=0x100; mstatus_o, mepc_o and a read of 0x341 all 0; after 5 non-reset edges, a read of 0xC00 returns 5.
- ex write 0x340 = 32'hDEAD_BEEF with csr_raddr_i=0x340 in the same cycle -> csr_rdata_o=0xDEADBEEF that cycle; clint_rdata_o on 0x340 shows it only after the edge.
- Same-cycle writes to 0x341, ex 32'h1111_1111 and clint 32'h2222_2222 -> mepc_o=0x22222222 after the edge.
- ex write 0xB00 = 32'hFFFF_FFFF with mcycleh=0 -> next cycle 0xC00 reads 0xFFFFFFFF; after one more edge, 0xC00 reads 0 and 0xC80 reads 1.
- Write 0x300 = 32'h8, then write 0xC00 = 32'h5 and write 0x7FF = 32'h1 -> global_int_en_o=1; counter unaffected by the 0xC00 write; read of 0x7FF returns 0.
- Assert rst for one cycle mid-count while ex writes 0x305 -> mtvec_o returns to MTVEC_RESET and the counter restarts from 0.
